// File: rtl/sensor_snapshot_regs.sv
// sensor_snapshot_regs
//   Byte-addressed register bank for the flight-sensor readout path.
//   Each of NUM_CH channels keeps a live word of CH_BYTES bytes, captured on
//   its ch_valid strobe. A snapshot copies every live word plus the per-channel
//   stale flags into a shadow bank in one edge, so multi-byte reads of the
//   shadow are always coherent. Reads only ever see the shadow bank.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   ch_data   in   live sensor words, channel k at [k*CH_BYTES*8 +: CH_BYTES*8]
//   ch_valid  in   per-channel update strobe (1-cycle pulse)
//   snap_req  in   explicit snapshot request pulse
//   rd_req    in   read request, may be asserted every cycle
//   rd_addr   in   byte address, sampled with rd_req
//   rd_data   out  read data, valid while rd_ack=1, otherwise holds last value
//   rd_ack    out  read completion, one cycle per accepted request
//   rd_err    out  out-of-range flag, qualified by rd_ack
//   snap_seq  out  snapshot sequence number (mod 256)
//
// Address map (NB = NUM_CH*CH_BYTES, SB = ceil(NUM_CH/8))
//   0                  snap_seq
//   1 .. NB            shadow channel k byte j (j=0 is MSB) at 1 + k*CH_BYTES + j
//   NB+1 .. NB+SB      shadow stale bitmap, channel k at byte NB+1+k/8, bit k%8
//   above              reads 0x00 with rd_err=1
//
// Read handshake: a request is accepted on every rising edge where rd_req=1;
// there is no backpressure. The accepting edge registers rd_ack=1 together
// with rd_data/rd_err, so the completion is visible for exactly the following
// cycle. The returned data reflects any snapshot taken on that same edge
// (including the auto-snapshot of an address-0 read). Reset clears rd_ack
// immediately, so a completion in flight is dropped.

module sensor_snapshot_regs #(
  parameter int NUM_CH      = 12,
  parameter int CH_BYTES    = 2,
  parameter int ADDR_W      = 8,
  parameter int AGE_W       = 16,
  parameter int STALE_LIMIT = 1000,
  parameter int AUTO_SNAP   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*CH_BYTES*8-1:0]   ch_data,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic                           snap_req,
  input  logic                           rd_req,
  input  logic [ADDR_W-1:0]              rd_addr,
  output logic [7:0]                     rd_data,
  output logic                           rd_ack,
  output logic                           rd_err,
  output logic [7:0]                     snap_seq
);

  localparam int CW = CH_BYTES * 8;           // bits per channel
  localparam int NB = NUM_CH * CH_BYTES;      // shadow data bytes
  localparam int SB = (NUM_CH + 7) / 8;       // stale bitmap bytes
  localparam int DW = NB * 8;

  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [AGE_W-1:0] STALE_TH = AGE_W'(STALE_LIMIT);

  logic [DW-1:0]     live_q;
  logic [DW-1:0]     live_nxt;
  logic [DW-1:0]     shadow_q;
  logic [DW-1:0]     shadow_nxt;
  logic [AGE_W-1:0]  age_q [NUM_CH];
  logic [NUM_CH-1:0] stale_cap;
  logic [NUM_CH-1:0] shadow_stale_q;
  logic [NUM_CH-1:0] shadow_stale_nxt;
  logic [SB*8-1:0]   stale_pad;
  logic              snap;
  logic [7:0]        seq_nxt;
  logic [7:0]        rd_data_nxt;
  logic              rd_err_nxt;
  int                addr_i;

  // Next-state of the live and shadow banks. live_nxt already contains any
  // word arriving this cycle, so loading the shadow from live_nxt gives the
  // same-cycle bypass for free. A channel updating on the snapshot edge is
  // by definition fresh, so its captured stale flag is forced to 0.
  always_comb begin
    snap      = snap_req | ((AUTO_SNAP != 0) & rd_req & (rd_addr == '0));
    live_nxt  = live_q;
    stale_cap = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_valid[k]) begin
        live_nxt[k*CW +: CW] = ch_data[k*CW +: CW];
      end
      stale_cap[k] = ~ch_valid[k] & (age_q[k] >= STALE_TH);
    end
    shadow_nxt       = snap ? live_nxt  : shadow_q;
    shadow_stale_nxt = snap ? stale_cap : shadow_stale_q;
    seq_nxt          = snap ? snap_seq + 8'd1 : snap_seq;
  end

  // Read decode works on the post-snapshot view so a read on the snapshot
  // edge already returns the new contents.
  always_comb begin
    addr_i      = int'(rd_addr);
    stale_pad   = '0;
    stale_pad[NUM_CH-1:0] = shadow_stale_nxt;
    rd_data_nxt = '0;
    rd_err_nxt  = (addr_i > NB + SB);
    if (addr_i == 0) begin
      rd_data_nxt = seq_nxt;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      for (int j = 0; j < CH_BYTES; j++) begin
        if (addr_i == 1 + k*CH_BYTES + j) begin
          rd_data_nxt = shadow_nxt[k*CW + (CH_BYTES-1-j)*8 +: 8];
        end
      end
    end
    for (int s = 0; s < SB; s++) begin
      if (addr_i == NB + 1 + s) begin
        rd_data_nxt = stale_pad[s*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q         <= '0;
      shadow_q       <= '0;
      shadow_stale_q <= '1;
      snap_seq       <= '0;
      rd_data        <= '0;
      rd_ack         <= 1'b0;
      rd_err         <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        age_q[k] <= AGE_MAX;
      end
    end else begin
      live_q         <= live_nxt;
      shadow_q       <= shadow_nxt;
      shadow_stale_q <= shadow_stale_nxt;
      snap_seq       <= seq_nxt;
      rd_ack         <= rd_req;
      rd_err         <= rd_req & rd_err_nxt;
      if (rd_req) begin
        rd_data <= rd_data_nxt;
      end
      // Ages saturate so a long-dead sensor never wraps back to "fresh".
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_valid[k]) begin
          age_q[k] <= '0;
        end else if (age_q[k] != AGE_MAX) begin
          age_q[k] <= age_q[k] + AGE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_snapshot_regs.sv
// Testbench for sensor_snapshot_regs (default parameters).
// Reference model: per-channel live/shadow words, the edge index of each
// channel's last update, and the snapshot counter; expected read results are
// queued in exp_q and popped when the completion is due.

module tb_sensor_snapshot_regs;

  localparam int NUM_CH   = 12;
  localparam int CH_BYTES = 2;
  localparam int ADDR_W   = 8;
  localparam int NB       = NUM_CH * CH_BYTES;
  localparam int SB       = 2;
  localparam int W        = NUM_CH * CH_BYTES * 8;
  localparam int LIMIT    = 1000;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      ch_data;
  logic [NUM_CH-1:0] ch_valid;
  logic              snap_req;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_ack;
  logic              rd_err;
  logic [7:0]        snap_seq;

  always #5 clk = ~clk;

  sensor_snapshot_regs #(
    .NUM_CH(NUM_CH), .CH_BYTES(CH_BYTES), .ADDR_W(ADDR_W),
    .AGE_W(16), .STALE_LIMIT(LIMIT), .AUTO_SNAP(1)
  ) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .snap_req(snap_req), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ack(rd_ack), .rd_err(rd_err), .snap_seq(snap_seq)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- reference model ----------------
  logic [15:0] m_live   [NUM_CH];
  logic [15:0] m_shadow [NUM_CH];
  bit          m_sstale [NUM_CH];
  int          m_last   [NUM_CH];   // edge index of last update, -1 = never
  logic [7:0]  m_seq;
  int          t_now = 0;
  logic [8:0]  exp_q [$];           // {err, data}
  logic [8:0]  exp_v;
  bit          exp_ack;

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_live[k] = '0; m_shadow[k] = '0; m_sstale[k] = 1'b1; m_last[k] = -1;
    end
    m_seq = '0;
    exp_q.delete();
  endtask

  // Age held just before edge t is the number of edges since the update edge, minus one.
  function automatic bit model_stale(int k, int t);
    if (m_last[k] < 0) return 1'b1;
    return (t - m_last[k] - 1) >= LIMIT;
  endfunction

  function automatic logic [8:0] model_read(int a);
    logic [7:0] b;
    int idx, ch;
    if (a == 0) return {1'b0, m_seq};
    if (a <= NB) begin
      idx = a - 1;
      ch  = idx / CH_BYTES;
      return (idx % CH_BYTES == 0) ? {1'b0, m_shadow[ch][15:8]} : {1'b0, m_shadow[ch][7:0]};
    end
    if (a <= NB + SB) begin
      b = '0;
      for (int i = 0; i < 8; i++) begin
        ch = (a - NB - 1) * 8 + i;
        if (ch < NUM_CH) b[i] = m_sstale[ch];
      end
      return {1'b0, b};
    end
    return 9'h100;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] x;
    for (int i = 0; i < W/32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  function automatic logic [W-1:0] with_ch(int k, logic [15:0] val);
    logic [W-1:0] x;
    x = rand_data();
    x[k*16 +: 16] = val;
    return x;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(int k);
    logic [NUM_CH-1:0] x;
    x = '0;
    x[k] = 1'b1;
    return x;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, and leave
  // time at 1 unit after the edge for sampling.
  task automatic cycle(input logic [NUM_CH-1:0] v, input logic [W-1:0] d,
                       input logic s, input logic r, input logic [7:0] a);
    ch_valid = v; ch_data = d; snap_req = s; rd_req = r; rd_addr = a;
    @(posedge clk);
    if (s || (r && a == 8'd0)) begin
      m_seq = m_seq + 8'd1;
      for (int k = 0; k < NUM_CH; k++) begin
        m_shadow[k] = v[k] ? d[k*16 +: 16] : m_live[k];
        m_sstale[k] = v[k] ? 1'b0 : model_stale(k, t_now);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (v[k]) begin
        m_live[k] = d[k*16 +: 16];
        m_last[k] = t_now;
      end
    end
    exp_ack = r;
    if (r) exp_q.push_back(model_read(int'(a)));
    t_now++;
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cycle('0, rand_data(), 1'b0, 1'b0, 8'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1; ch_valid = '0; ch_data = '0; snap_req = 1'b0; rd_req = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int addrs[3];
    logic [7:0] lit[3];
    addrs = '{25, 26, 0};
    lit   = '{8'hFF, 8'h0F, 8'h01};
    rst = 1'b1; ch_valid = '0; ch_data = '0; snap_req = 1'b0; rd_req = 1'b1; rd_addr = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (rd_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    vec_cnt++; if (rd_ack !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack); end
    vec_cnt++; if (rd_err !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
    vec_cnt++; if (snap_seq !== 8'h00) begin err_cnt++; $display("FAIL reset_snap_seq: got %h want 00", snap_seq); end
    rd_req = 1'b0;
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle('0, rand_data(), 1'b0, 1'b1, 8'(addrs[i]));
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (rd_ack !== 1'b1 || {rd_err, rd_data} !== exp_v) begin
        err_cnt++; $display("FAIL reset_read_model addr %0d: got ack %b err/data %h want ack 1 err/data %h", addrs[i], rd_ack, {rd_err, rd_data}, exp_v);
      end
      vec_cnt++;
      if (rd_data !== lit[i] || rd_err !== 1'b0) begin
        err_cnt++; $display("FAIL reset_read_const addr %0d: got %h err %b want %h err 0", addrs[i], rd_data, rd_err, lit[i]);
      end
    end
    cycle('0, rand_data(), 1'b0, 1'b0, 8'd0);
    vec_cnt++; if (rd_ack !== 1'b0) begin err_cnt++; $display("FAIL idle_ack: got %b want 0", rd_ack); end
  endtask

  task automatic test_capture();
    cycle(onehot(3), with_ch(3, 16'hBEEF), 1'b0, 1'b0, 8'd0);
    cycle('0, rand_data(), 1'b1, 1'b0, 8'd0);
    cycle('0, rand_data(), 1'b0, 1'b1, 8'd7);
    exp_v = exp_q.pop_front();
    vec_cnt++; if (rd_ack !== 1'b1 || rd_data !== 8'hBE || {rd_err, rd_data} !== exp_v) begin
      err_cnt++; $display("FAIL capture_addr7: got ack %b data %h want ack 1 data be (model %h)", rd_ack, rd_data, exp_v); end
    cycle('0, rand_data(), 1'b0, 1'b1, 8'd8);
    exp_v = exp_q.pop_front();
    vec_cnt++; if (rd_ack !== 1'b1 || rd_data !== 8'hEF || {rd_err, rd_data} !== exp_v) begin
      err_cnt++; $display("FAIL capture_addr8: got ack %b data %h want ack 1 data ef (model %h)", rd_ack, rd_data, exp_v); end
    cycle('0, rand_data(), 1'b0, 1'b1, 8'd25);
    exp_v = exp_q.pop_front();
    vec_cnt++; if (rd_data[3] !== 1'b0 || {rd_err, rd_data} !== exp_v) begin
      err_cnt++; $display("FAIL capture_stale_bit3: got byte %h want bit3=0 (model %h)", rd_data, exp_v); end
  endtask

  task automatic test_shadow_hold();
    int addrs[5];
    logic [7:0] lit[5];
    addrs = '{7, 8, 0, 7, 8};
    lit   = '{8'hBE, 8'hEF, 8'h00, 8'h12, 8'h34};
    cycle(onehot(3), with_ch(3, 16'h1234), 1'b0, 1'b0, 8'd0);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      cycle('0, rand_data(), 1'b0, 1'b1, 8'(addrs[i]));
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (rd_ack !== 1'b1 || {rd_err, rd_data} !== exp_v) begin
        err_cnt++; $display("FAIL hold_model addr %0d: got ack %b err/data %h want ack 1 err/data %h", addrs[i], rd_ack, {rd_err, rd_data}, exp_v);
      end
      if (addrs[i] != 0) begin
        vec_cnt++;
        if (rd_data !== lit[i]) begin
          err_cnt++; $display("FAIL hold_const addr %0d step %0d: got %h want %h", addrs[i], i, rd_data, lit[i]);
        end
      end
    end
  endtask

  task automatic test_stale();
    // idle 999: snapshot sees age 999 -> fresh; idle 1000: age 1000 -> stale
    int gaps[2];
    logic want[2];
    gaps = '{999, 1000};
    want = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      cycle(onehot(0), with_ch(0, 16'($urandom)), 1'b0, 1'b0, 8'd0);
      idle(gaps[i]);
      cycle('0, rand_data(), 1'b1, 1'b1, 8'd25);
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (rd_ack !== 1'b1 || rd_data[0] !== want[i] || {rd_err, rd_data} !== exp_v) begin
        err_cnt++; $display("FAIL stale_gap_%0d: got ack %b byte %h want ack 1 bit0 %b (model %h)", gaps[i], rd_ack, rd_data, want[i], exp_v);
      end
    end
  endtask

  task automatic test_bypass();
    int addrs[3];
    logic [7:0] s0;
    addrs = '{11, 12, 25};
    cycle(onehot(5), with_ch(5, 16'hA5A5), 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cycle('0, rand_data(), 1'b0, 1'b1, 8'(addrs[i]));
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (rd_ack !== 1'b1 || {rd_err, rd_data} !== exp_v ||
          (i < 2 && rd_data !== 8'hA5) || (i == 2 && rd_data[5] !== 1'b0)) begin
        err_cnt++; $display("FAIL bypass addr %0d: got ack %b err/data %h want ack 1 err/data %h", addrs[i], rd_ack, {rd_err, rd_data}, exp_v);
      end
    end
    // explicit request plus auto-snapshot in one cycle counts once
    s0 = m_seq;
    cycle('0, rand_data(), 1'b1, 1'b1, 8'd0);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (rd_data !== s0 + 8'd1 || snap_seq !== s0 + 8'd1 || {rd_err, rd_data} !== exp_v) begin
      err_cnt++; $display("FAIL double_snap: got data %h seq %h want %h", rd_data, snap_seq, s0 + 8'd1);
    end
  endtask

  task automatic test_back_to_back();
    int addrs[4];
    logic [8:0] lit[4];
    addrs = '{1, 27, 200, 7};
    lit   = '{9'h000, 9'h100, 9'h100, 9'h012};
    for (int i = 0; i < 4; i++) begin
      cycle('0, rand_data(), 1'b0, 1'b1, 8'(addrs[i]));
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (rd_ack !== 1'b1 || {rd_err, rd_data} !== exp_v) begin
        err_cnt++; $display("FAIL b2b_model addr %0d: got ack %b err/data %h want ack 1 err/data %h", addrs[i], rd_ack, {rd_err, rd_data}, exp_v);
      end
      if (addrs[i] != 1) begin
        vec_cnt++;
        if ({rd_err, rd_data} !== lit[i]) begin
          err_cnt++; $display("FAIL b2b_const addr %0d: got err/data %h want %h", addrs[i], {rd_err, rd_data}, lit[i]);
        end
      end
    end
    cycle('0, rand_data(), 1'b0, 1'b0, 8'd0);
    vec_cnt++;
    if (rd_ack !== 1'b0 || rd_data !== 8'h12) begin
      err_cnt++; $display("FAIL b2b_hold: got ack %b data %h want ack 0 data 12", rd_ack, rd_data);
    end
  endtask

  task automatic test_seq_wrap();
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      cycle('0, rand_data(), 1'b1, 1'b0, 8'd0);
      vec_cnt++;
      if (snap_seq !== m_seq) begin
        err_cnt++; $display("FAIL seq_step %0d: got %h want %h", i, snap_seq, m_seq);
      end
    end
    vec_cnt++;
    if (snap_seq !== 8'h00) begin err_cnt++; $display("FAIL seq_wrap: got %h want 00", snap_seq); end
  endtask

  task automatic test_reset_mid_read();
    cycle('0, rand_data(), 1'b0, 1'b1, 8'd1);
    exp_v = exp_q.pop_front();
    vec_cnt++; if (rd_ack !== 1'b1) begin err_cnt++; $display("FAIL pre_reset_ack: got %b want 1", rd_ack); end
    rd_req = 1'b1; rd_addr = 8'd3;
    rst = 1'b1;
    #1;
    vec_cnt++; if (rd_ack !== 1'b0) begin err_cnt++; $display("FAIL reset_drops_ack: got %b want 0", rd_ack); end
    @(posedge clk);
    #1;
    vec_cnt++; if (rd_ack !== 1'b0) begin err_cnt++; $display("FAIL reset_hold_ack: got %b want 0", rd_ack); end
    rd_req = 1'b0;
    model_reset();
    rst = 1'b0;
    cycle('0, rand_data(), 1'b0, 1'b0, 8'd0);
    vec_cnt++; if (rd_ack !== 1'b0) begin err_cnt++; $display("FAIL post_reset_ack: got %b want 0", rd_ack); end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] v;
    logic s, r;
    logic [7:0] a;
    for (int n = 0; n < 2500; n++) begin
      for (int k = 0; k < NUM_CH; k++)
        v[k] = (k < 6) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 899) == 0);
      s = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 28));
      cycle(v, rand_data(), s, r, a);
      vec_cnt++;
      if (rd_ack !== exp_ack) begin
        err_cnt++; $display("FAIL rand_ack cyc %0d: got %b want %b", n, rd_ack, exp_ack);
      end
      if (exp_ack) begin
        exp_v = exp_q.pop_front();
        vec_cnt++;
        if ({rd_err, rd_data} !== exp_v) begin
          err_cnt++; $display("FAIL rand_read cyc %0d addr %0d: got err/data %h want %h", n, a, {rd_err, rd_data}, exp_v);
        end
      end
      vec_cnt++;
      if (snap_seq !== m_seq) begin
        err_cnt++; $display("FAIL rand_seq cyc %0d: got %h want %h", n, snap_seq, m_seq);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_capture();
    test_shadow_hold();
    test_stale();
    test_bypass();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    test_seq_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
